// File: rtl/gb_trace_pkg.sv
// Shared types and helpers for the GB psum trace counter.
// Holds the FSM state enum, read-map layout helpers and a saturating increment.
package gb_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } trace_state_t;

    localparam int RD_BASE = 0;

    function automatic int wr_base(input int depth);
        return depth;
    endfunction

    function automatic int pool_base(input int depth);
        return 2 * depth;
    endfunction

    function automatic int stat_addr(input int depth, input int pdepth);
        return 2 * depth + pdepth;
    endfunction

    function automatic int lost_addr(input int depth, input int pdepth);
        return 2 * depth + pdepth + 1;
    endfunction

    function automatic int clr_len(input int depth, input int pdepth);
        return (depth > pdepth) ? depth : pdepth;
    endfunction

    // Increment v, holding at the all-ones value of a w-bit counter.
    function automatic logic [31:0] sat_inc(
        input logic [31:0] v,
        input int          w
    );
        logic [31:0] lim;
        lim = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (v >= lim) ? lim : v + 32'd1;
    endfunction

endpackage

// File: rtl/gb_psum_trace_counter_seg_check.sv
// Per-channel segment beat counters and sticky mismatch flags.
// Ports: Clk/Rst, run/clr qualifiers, frame/block position, per-channel
// read/write handshakes in; per-channel sticky mismatch out.
module gb_trace_seg_check
    import gb_trace_pkg::*;
#(
    parameter int NUM_CH = 16,
    parameter int CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              run,
    input  logic              clr,
    input  logic              reset_patch,
    input  logic [5:0]        cur_frame,
    input  logic [5:0]        cur_block,
    input  logic [NUM_CH-1:0] rd_hs,
    input  logic [NUM_CH-1:0] wr_hs,
    output logic [NUM_CH-1:0] mismatch
);

    logic [CNT_W-1:0]  seg_rd [NUM_CH];
    logic [CNT_W-1:0]  seg_wr [NUM_CH];
    logic [5:0]        prev_frame;
    logic [5:0]        prev_block;
    logic              bnd;
    logic [NUM_CH-1:0] diff;

    assign bnd = run && ((cur_frame != prev_frame) ||
                         (cur_block != prev_block) ||
                         reset_patch);

    // Channel 0 is the reference every other channel must match.
    always_comb begin
        diff = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            diff[c] = (seg_rd[c] != seg_rd[0]) ||
                      (seg_wr[c] != seg_wr[0]);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            prev_frame <= '0;
            prev_block <= '0;
            mismatch   <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                seg_rd[c] <= '0;
                seg_wr[c] <= '0;
            end
        end else begin
            prev_frame <= cur_frame;
            prev_block <= cur_block;
            if (clr) begin
                mismatch <= '0;
            end else if (bnd) begin
                mismatch <= mismatch | diff;
            end
            // The boundary cycle's own beat opens the next segment.
            for (int c = 0; c < NUM_CH; c++) begin
                if (!run) begin
                    seg_rd[c] <= '0;
                    seg_wr[c] <= '0;
                end else if (bnd) begin
                    seg_rd[c] <= CNT_W'(rd_hs[c]);
                    seg_wr[c] <= CNT_W'(wr_hs[c]);
                end else begin
                    if (rd_hs[c])
                        seg_rd[c] <= CNT_W'(sat_inc(32'(seg_rd[c]), CNT_W));
                    if (wr_hs[c])
                        seg_wr[c] <= CNT_W'(sat_inc(32'(seg_wr[c]), CNT_W));
                end
            end
        end
    end

endmodule

// File: rtl/gb_psum_trace_counter.sv
// Passive traffic monitor for the GB psum read/write/pool handshakes.
// Ports: Clk/Rst; start/reset_patch patch control; cfg/cur frame+block;
// per-channel psum rd/wr handshakes; pool handshake with is_expo;
// rd_req/rd_addr -> rd_vld/rd_data register-style table read;
// status outputs busy, done, patch_cnt, mismatch, ovf, lost_cnt.
module gb_psum_trace_counter
    import gb_trace_pkg::*;
#(
    parameter int NUM_CH     = 16,
    parameter int CNT_W      = 16,
    parameter int DEPTH      = 64,
    parameter int POOL_DEPTH = 34,
    parameter int ADDR_W     = $clog2(2*DEPTH+POOL_DEPTH+2)
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              start,
    input  logic              reset_patch,
    input  logic [5:0]        cfg_num_frame,
    input  logic [5:0]        cfg_num_block,
    input  logic [5:0]        cur_frame,
    input  logic [5:0]        cur_block,
    input  logic [NUM_CH-1:0] psum_rd_vld,
    input  logic [NUM_CH-1:0] psum_rd_rdy,
    input  logic [NUM_CH-1:0] psum_wr_vld,
    input  logic [NUM_CH-1:0] psum_wr_rdy,
    input  logic              pool_vld,
    input  logic              pool_rdy,
    input  logic              is_expo,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_vld,
    output logic [CNT_W-1:0]  rd_data,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  patch_cnt,
    output logic [NUM_CH-1:0] mismatch,
    output logic              ovf,
    output logic [CNT_W-1:0]  lost_cnt
);

    localparam int CLR_LEN = clr_len(DEPTH, POOL_DEPTH);
    localparam int IW      = $clog2(DEPTH);
    localparam int PW      = $clog2(POOL_DEPTH);
    localparam int CW      = $clog2(CLR_LEN);
    localparam int WR_B    = wr_base(DEPTH);
    localparam int PL_B    = pool_base(DEPTH);
    localparam int ST_A    = stat_addr(DEPTH, POOL_DEPTH);
    localparam int LO_A    = lost_addr(DEPTH, POOL_DEPTH);

    trace_state_t      state;
    trace_state_t      state_nxt;
    logic [CW-1:0]     clr_idx;
    logic              clr_last;
    logic              enter_clr;
    logic              in_clr;
    logic              run_upd;

    logic [CNT_W-1:0]  rd_tab   [DEPTH];
    logic [CNT_W-1:0]  wr_tab   [DEPTH];
    logic [CNT_W-1:0]  pool_tab [POOL_DEPTH];

    logic [NUM_CH-1:0] rd_hs;
    logic [NUM_CH-1:0] wr_hs;
    logic              ev_rd;
    logic              ev_wr;
    logic              ev_pl;
    logic [11:0]       blk_n;
    logic [11:0]       idx;
    logic [6:0]        pidx;
    logic              idx_ok;
    logic              pidx_ok;
    logic [IW-1:0]     ti;
    logic [PW-1:0]     pi;

    logic [1:0]        lost_n;
    logic [CNT_W+1:0]  lost_sum;
    logic [CNT_W-1:0]  lost_nxt;

    logic [ADDR_W-1:0] wr_off;
    logic [ADDR_W-1:0] pl_off;
    logic [CNT_W-1:0]  rd_mux;

    // Frame count does not bound anything: the table depth does.
    logic              unused_cfg;
    assign unused_cfg = ^cfg_num_frame;

    // ---------------- control FSM ----------------
    assign clr_last = (clr_idx == CW'(CLR_LEN - 1));

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (start) state_nxt = ST_CLEAR;
            ST_CLEAR: if (clr_last) state_nxt = ST_RUN;
            ST_RUN: begin
                if (start)            state_nxt = ST_CLEAR;
                else if (reset_patch) state_nxt = ST_DONE;
            end
            ST_DONE:  state_nxt = start ? ST_CLEAR : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state   <= ST_IDLE;
            clr_idx <= '0;
        end else begin
            state   <= state_nxt;
            if (state == ST_CLEAR && !clr_last)
                clr_idx <= clr_idx + CW'(1);
            else
                clr_idx <= '0;
        end
    end

    assign in_clr    = (state == ST_CLEAR);
    assign enter_clr = (state_nxt == ST_CLEAR) && !in_clr;
    // A restart abandons the traffic of the cycle it arrives in.
    assign run_upd   = (state == ST_RUN) && !start;

    assign busy = in_clr || (state == ST_RUN);
    assign done = (state == ST_DONE);

    // ---------------- event decode ----------------
    assign rd_hs = psum_rd_vld & psum_rd_rdy;
    assign wr_hs = psum_wr_vld & psum_wr_rdy;
    assign ev_rd = rd_hs[0];
    assign ev_wr = wr_hs[0];
    assign ev_pl = pool_vld & pool_rdy;

    assign blk_n   = {6'b0, cfg_num_block} + 12'd1;
    assign idx     = ({6'b0, cur_frame} * blk_n) + {6'b0, cur_block};
    assign pidx    = {1'b0, cur_frame} + {6'b0, is_expo};
    assign idx_ok  = (idx < 12'(DEPTH));
    assign pidx_ok = (pidx < 7'(POOL_DEPTH));
    assign ti      = idx[IW-1:0];
    assign pi      = pidx[PW-1:0];

    // ---------------- count tables ----------------
    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                rd_tab[i] <= '0;
                wr_tab[i] <= '0;
            end
            for (int i = 0; i < POOL_DEPTH; i++) begin
                pool_tab[i] <= '0;
            end
        end else if (in_clr) begin
            if (int'(clr_idx) < DEPTH) begin
                rd_tab[clr_idx[IW-1:0]] <= '0;
                wr_tab[clr_idx[IW-1:0]] <= '0;
            end
            if (int'(clr_idx) < POOL_DEPTH)
                pool_tab[clr_idx[PW-1:0]] <= '0;
        end else if (run_upd) begin
            if (ev_rd && idx_ok)
                rd_tab[ti] <= CNT_W'(sat_inc(32'(rd_tab[ti]), CNT_W));
            if (ev_wr && idx_ok)
                wr_tab[ti] <= CNT_W'(sat_inc(32'(wr_tab[ti]), CNT_W));
            if (ev_pl && pidx_ok)
                pool_tab[pi] <= CNT_W'(sat_inc(32'(pool_tab[pi]), CNT_W));
        end
    end

    // ---------------- status counters ----------------
    // Up to three tracked handshakes can be lost in one CLEAR cycle.
    assign lost_n   = {1'b0, ev_rd} + {1'b0, ev_wr} + {1'b0, ev_pl};
    assign lost_sum = {2'b00, lost_cnt} + (CNT_W+2)'(lost_n);
    assign lost_nxt = (lost_sum[CNT_W+1:CNT_W] != 2'b00) ?
                      '1 : lost_sum[CNT_W-1:0];

    always_ff @(posedge Clk) begin
        if (Rst) begin
            patch_cnt <= '0;
            ovf       <= 1'b0;
            lost_cnt  <= '0;
        end else begin
            if (enter_clr) begin
                ovf      <= 1'b0;
                lost_cnt <= '0;
            end else begin
                if (run_upd && (((ev_rd || ev_wr) && !idx_ok) ||
                                (ev_pl && !pidx_ok)))
                    ovf <= 1'b1;
                if (in_clr)
                    lost_cnt <= lost_nxt;
            end
            if (state == ST_RUN && state_nxt == ST_DONE)
                patch_cnt <= CNT_W'(sat_inc(32'(patch_cnt), CNT_W));
        end
    end

    // ---------------- segment checker ----------------
    gb_trace_seg_check #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W)
    ) u_seg (
        .Clk         (Clk),
        .Rst         (Rst),
        .run         (run_upd),
        .clr         (enter_clr),
        .reset_patch (reset_patch),
        .cur_frame   (cur_frame),
        .cur_block   (cur_block),
        .rd_hs       (rd_hs),
        .wr_hs       (wr_hs),
        .mismatch    (mismatch)
    );

    // ---------------- read port ----------------
    assign wr_off = rd_addr - ADDR_W'(WR_B);
    assign pl_off = rd_addr - ADDR_W'(PL_B);

    always_comb begin
        rd_mux = '0;
        unique case (1'b1)
            (rd_addr < ADDR_W'(WR_B)):
                rd_mux = rd_tab[rd_addr[IW-1:0]];
            (rd_addr >= ADDR_W'(WR_B) && rd_addr < ADDR_W'(PL_B)):
                rd_mux = wr_tab[wr_off[IW-1:0]];
            (rd_addr >= ADDR_W'(PL_B) && rd_addr < ADDR_W'(ST_A)):
                rd_mux = pool_tab[pl_off[PW-1:0]];
            (rd_addr == ADDR_W'(ST_A)):
                rd_mux = CNT_W'({|mismatch, ovf, state});
            (rd_addr == ADDR_W'(LO_A)):
                rd_mux = lost_cnt;
            default:
                rd_mux = '0;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            rd_vld  <= 1'b0;
            rd_data <= '0;
        end else begin
            rd_vld  <= rd_req;
            rd_data <= rd_req ? rd_mux : '0;
        end
    end

endmodule

// File: tb/tb_gb_psum_trace_counter.sv
// Self-checking bench for gb_psum_trace_counter.
// Directed patch scenarios plus random traffic against a behavioural model.
module tb_gb_psum_trace_counter;

    localparam int NUM_CH     = 16;
    localparam int CNT_W      = 16;
    localparam int DEPTH      = 64;
    localparam int POOL_DEPTH = 34;
    localparam int ADDR_W     = $clog2(2*DEPTH+POOL_DEPTH+2);
    localparam int CLR_CYC    = 64;
    localparam int ST_A       = 2*DEPTH+POOL_DEPTH;
    localparam int LO_A       = ST_A+1;
    localparam int MAXC       = 65535;

    logic              Clk;
    logic              Rst;
    logic              start;
    logic              reset_patch;
    logic [5:0]        cfg_num_frame;
    logic [5:0]        cfg_num_block;
    logic [5:0]        cur_frame;
    logic [5:0]        cur_block;
    logic [NUM_CH-1:0] psum_rd_vld;
    logic [NUM_CH-1:0] psum_rd_rdy;
    logic [NUM_CH-1:0] psum_wr_vld;
    logic [NUM_CH-1:0] psum_wr_rdy;
    logic              pool_vld;
    logic              pool_rdy;
    logic              is_expo;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_vld;
    logic [CNT_W-1:0]  rd_data;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  patch_cnt;
    logic [NUM_CH-1:0] mismatch;
    logic              ovf;
    logic [CNT_W-1:0]  lost_cnt;

    gb_psum_trace_counter #(
        .NUM_CH     (NUM_CH),
        .CNT_W      (CNT_W),
        .DEPTH      (DEPTH),
        .POOL_DEPTH (POOL_DEPTH),
        .ADDR_W     (ADDR_W)
    ) dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .start         (start),
        .reset_patch   (reset_patch),
        .cfg_num_frame (cfg_num_frame),
        .cfg_num_block (cfg_num_block),
        .cur_frame     (cur_frame),
        .cur_block     (cur_block),
        .psum_rd_vld   (psum_rd_vld),
        .psum_rd_rdy   (psum_rd_rdy),
        .psum_wr_vld   (psum_wr_vld),
        .psum_wr_rdy   (psum_wr_rdy),
        .pool_vld      (pool_vld),
        .pool_rdy      (pool_rdy),
        .is_expo       (is_expo),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .rd_vld        (rd_vld),
        .rd_data       (rd_data),
        .busy          (busy),
        .done          (done),
        .patch_cnt     (patch_cnt),
        .mismatch      (mismatch),
        .ovf           (ovf),
        .lost_cnt      (lost_cnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model: phase 0 idle, 1 clear, 2 run, 3 done.
    int              m_phase;
    int              m_clr_pos;
    int              m_rd   [DEPTH];
    int              m_wr   [DEPTH];
    int              m_pool [POOL_DEPTH];
    int              m_patch;
    int              m_lost;
    bit              m_ovf;
    bit [NUM_CH-1:0] m_mis;
    int              m_srd  [NUM_CH];
    int              m_swr  [NUM_CH];
    int              m_pf;
    int              m_pb;
    bit              m_rvld;
    int              m_rdata;

    int n_chk;
    int n_pass;
    int n_fail;
    bit live_chk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= MAXC) ? MAXC : v + 1;
    endfunction

    function automatic int model_read(input int a);
        if (a < DEPTH)           return m_rd[a];
        if (a < 2*DEPTH)         return m_wr[a-DEPTH];
        if (a < ST_A)            return m_pool[a-2*DEPTH];
        if (a == ST_A)
            return ((|m_mis) ? 8 : 0) + (m_ovf ? 4 : 0) + m_phase;
        if (a == LO_A)           return m_lost;
        return 0;
    endfunction

    task automatic seg_zero();
        for (int c = 0; c < NUM_CH; c++) begin
            m_srd[c] = 0;
            m_swr[c] = 0;
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_clr_pos = 0; m_patch = 0; m_lost = 0;
        m_ovf = 0; m_mis = '0; m_pf = 0; m_pb = 0;
        for (int i = 0; i < DEPTH; i++) begin
            m_rd[i] = 0;
            m_wr[i] = 0;
        end
        for (int i = 0; i < POOL_DEPTH; i++) m_pool[i] = 0;
        seg_zero();
    endtask

    task automatic enter_clear();
        m_phase = 1; m_clr_pos = 0;
        m_ovf = 0; m_lost = 0; m_mis = '0;
        seg_zero();
    endtask

    // Applies one clock edge's worth of spec behaviour to the model.
    task automatic model_step();
        int idx, pidx, lost;
        bit erd, ewr, epl, bnd;
        bit [NUM_CH-1:0] rh, wh;
        m_rvld  = rd_req;
        m_rdata = rd_req ? model_read(int'(rd_addr)) : 0;
        if (Rst) begin
            model_reset();
            m_rvld = 0; m_rdata = 0;
            return;
        end
        rh   = psum_rd_vld & psum_rd_rdy;
        wh   = psum_wr_vld & psum_wr_rdy;
        erd  = rh[0];
        ewr  = wh[0];
        epl  = pool_vld && pool_rdy;
        idx  = int'(cur_frame) * (int'(cfg_num_block) + 1) + int'(cur_block);
        pidx = int'(cur_frame) + int'(is_expo);
        case (m_phase)
            0: if (start) enter_clear();
            1: begin
                if (m_clr_pos < DEPTH) begin
                    m_rd[m_clr_pos] = 0;
                    m_wr[m_clr_pos] = 0;
                end
                if (m_clr_pos < POOL_DEPTH) m_pool[m_clr_pos] = 0;
                lost = m_lost + int'(erd) + int'(ewr) + int'(epl);
                m_lost = (lost > MAXC) ? MAXC : lost;
                m_clr_pos++;
                if (m_clr_pos == CLR_CYC) m_phase = 2;
            end
            2: begin
                if (start) enter_clear();
                else begin
                    if (erd) begin
                        if (idx < DEPTH) m_rd[idx] = sat(m_rd[idx]);
                        else m_ovf = 1;
                    end
                    if (ewr) begin
                        if (idx < DEPTH) m_wr[idx] = sat(m_wr[idx]);
                        else m_ovf = 1;
                    end
                    if (epl) begin
                        if (pidx < POOL_DEPTH) m_pool[pidx] = sat(m_pool[pidx]);
                        else m_ovf = 1;
                    end
                    bnd = (int'(cur_frame) != m_pf) ||
                          (int'(cur_block) != m_pb) || reset_patch;
                    if (bnd) begin
                        for (int c = 0; c < NUM_CH; c++)
                            if (m_srd[c] != m_srd[0] || m_swr[c] != m_swr[0])
                                m_mis[c] = 1;
                    end
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (bnd) begin
                            m_srd[c] = int'(rh[c]);
                            m_swr[c] = int'(wh[c]);
                        end else begin
                            if (rh[c]) m_srd[c] = sat(m_srd[c]);
                            if (wh[c]) m_swr[c] = sat(m_swr[c]);
                        end
                    end
                    if (reset_patch) begin
                        m_phase = 3;
                        m_patch = sat(m_patch);
                    end
                end
            end
            default: begin
                seg_zero();
                if (start) enter_clear();
                else m_phase = 0;
            end
        endcase
        if (m_phase == 0 || m_phase == 1) seg_zero();
        m_pf = int'(cur_frame);
        m_pb = int'(cur_block);
    endtask

    task automatic check_all();
        chk("busy", busy, (m_phase == 1 || m_phase == 2));
        chk("done", done, (m_phase == 3));
        chk("patch_cnt", patch_cnt, m_patch);
        chk("mismatch", mismatch, m_mis);
        chk("ovf", ovf, m_ovf);
        chk("lost_cnt", lost_cnt, m_lost);
        chk("rd_vld", rd_vld, m_rvld);
        if (m_rvld) chk("rd_data", rd_data, m_rdata);
    endtask

    task automatic tick();
        model_step();
        @(posedge Clk);
        #1;
        if (live_chk) check_all();
    endtask

    task automatic quiet();
        start = 0; reset_patch = 0;
        psum_rd_vld = '0; psum_rd_rdy = '0;
        psum_wr_vld = '0; psum_wr_rdy = '0;
        pool_vld = 0; pool_rdy = 0; is_expo = 0;
        rd_req = 0;
    endtask

    task automatic rd_beat(input logic [NUM_CH-1:0] m);
        psum_rd_vld = m; psum_rd_rdy = '1;
        tick();
        psum_rd_vld = '0; psum_rd_rdy = '0;
    endtask

    task automatic rd_at(input int a, input int exp, input string tag);
        rd_req = 1; rd_addr = ADDR_W'(a);
        tick();
        rd_req = 0;
        chk(tag, rd_data, exp);
    endtask

    task automatic begin_patch();
        start = 1; tick(); start = 0;
        chk("busy_rise", busy, 1'b1);
        repeat (CLR_CYC) tick();
    endtask

    task automatic end_patch();
        reset_patch = 1; tick(); reset_patch = 0;
        chk("done_pulse", done, 1'b1);
        tick();
    endtask

    initial begin
        n_chk = 0; n_pass = 0; n_fail = 0;
        live_chk = 1;
        model_reset();
        quiet();
        rd_addr = '0;
        cfg_num_frame = 6'd0; cfg_num_block = 6'd1;
        cur_frame = 6'd0; cur_block = 6'd0;
        Rst = 1;
        tick(); tick();
        Rst = 0;
        chk("rst_busy", busy, 1'b0);
        chk("rst_patch", patch_cnt, 16'd0);
        rd_at(0, 0, "rst_rd0");

        // Basic patch: 5 beats at F0B0, 3 at F0B1.
        begin_patch();
        repeat (5) rd_beat('1);
        cur_block = 6'd1;
        repeat (3) rd_beat('1);
        end_patch();
        chk("t1_patch", patch_cnt, 16'd1);
        chk("t1_mis", mismatch, 16'h0000);
        rd_at(0, 5, "t1_rd0");
        rd_at(1, 3, "t1_rd1");

        // Channel 7 one beat short at F0B0.
        cur_block = 6'd0;
        begin_patch();
        repeat (4) rd_beat('1);
        rd_beat(~(16'h0080));
        cur_block = 6'd1;
        tick();
        chk("t2_mis", mismatch, 16'h0080);
        repeat (3) rd_beat('1);
        end_patch();
        chk("t2_patch", patch_cnt, 16'd2);

        // Pool beats at frame 2, with and without is_expo.
        cfg_num_block = 6'd0; cur_frame = 6'd2; cur_block = 6'd0;
        begin_patch();
        pool_vld = 1; pool_rdy = 1;
        is_expo = 0; repeat (2) tick();
        is_expo = 1; repeat (3) tick();
        pool_vld = 0; pool_rdy = 0; is_expo = 0;
        end_patch();
        rd_at(2*DEPTH+2, 2, "t3_pool2");
        rd_at(2*DEPTH+3, 3, "t3_pool3");

        // Out-of-range table index.
        cfg_num_block = 6'd15; cur_frame = 6'd7; cur_block = 6'd0;
        begin_patch();
        psum_wr_vld = '1; psum_wr_rdy = '1;
        tick();
        psum_wr_vld = '0; psum_wr_rdy = '0;
        chk("t4_ovf", ovf, 1'b1);
        rd_at(DEPTH+0, 0, "t4_wr0");
        rd_at(DEPTH+48, 0, "t4_wr48");
        rd_at(ST_A, 6, "t4_status");
        end_patch();

        // Handshakes during CLEAR, then a restart from RUN.
        cfg_num_block = 6'd1; cur_frame = 6'd0; cur_block = 6'd0;
        start = 1; tick(); start = 0;
        repeat (3) rd_beat(16'h0001);
        repeat (CLR_CYC-3) tick();
        chk("t5_lost", lost_cnt, 16'd3);
        rd_at(LO_A, 3, "t5_lost_rd");
        start = 1; tick(); start = 0;
        chk("t5_busy", busy, 1'b1);
        chk("t5_patch", patch_cnt, 16'd4);
        chk("t5_lost0", lost_cnt, 16'd0);
        repeat (CLR_CYC) tick();

        // Random traffic against the model.
        cfg_num_block = 6'd3;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                cur_frame = 6'($urandom_range(0, 17));
                cur_block = 6'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 3) == 0)
                psum_rd_vld = 16'($urandom);
            else
                psum_rd_vld = ($urandom_range(0, 1) == 1) ? '1 : '0;
            psum_rd_rdy = ($urandom_range(0, 7) == 0) ? 16'($urandom) : '1;
            if ($urandom_range(0, 3) == 0)
                psum_wr_vld = 16'($urandom);
            else
                psum_wr_vld = ($urandom_range(0, 1) == 1) ? '1 : '0;
            psum_wr_rdy = '1;
            pool_vld = 1'($urandom);
            pool_rdy = 1'($urandom);
            is_expo  = 1'($urandom);
            rd_req   = 1'($urandom);
            rd_addr  = ADDR_W'($urandom_range(0, LO_A + 4));
            tick();
        end
        quiet();
        end_patch();
        for (int a = 0; a <= LO_A + 2; a++) begin
            rd_req = 1; rd_addr = ADDR_W'(a);
            tick();
        end
        rd_req = 0;

        // Saturation of one write counter.
        cfg_num_block = 6'd0; cur_frame = 6'd0; cur_block = 6'd0;
        begin_patch();
        live_chk = 0;
        psum_wr_vld = '1; psum_wr_rdy = '1;
        repeat (70000) tick();
        psum_wr_vld = '0; psum_wr_rdy = '0;
        live_chk = 1;
        tick();
        rd_at(DEPTH+0, MAXC, "t7_sat");

        // Reset in the middle of RUN.
        Rst = 1; tick(); Rst = 0;
        chk("t8_busy", busy, 1'b0);
        chk("t8_patch", patch_cnt, 16'd0);
        rd_at(DEPTH+0, 0, "t8_wr0");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
